uart_rx_pkt_parser: RTL and testbench
=====================================

Name: uart_rx_pkt_parser

Overview:
Downstream consumer of the UART receiver. It takes one received byte per rx_valid strobe and recognises frames of the form SOF, LEN, payload, CHK. Each payload is buffered internally. Only frames with a good checksum are released to the core, as a valid/ready byte stream with a last marker. Malformed, stalled or overrun traffic is dropped and flagged.

Parameters:
MAX_LEN, 16, maximum payload length in bytes (1..255); sets the depth of the payload buffer.
SOF, 8'hAA, start-of-frame byte value.
TIMEOUT_CLKS, 8700, maximum clocks allowed between bytes inside a frame (about 10 byte times at 87 clks/bit).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
rx_byte  in  8  byte from the UART receiver.
rx_valid  in  1  one-cycle strobe; rx_byte is valid in the same cycle.
out_data  out  8  payload byte.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream accepts; a transfer occurs on out_valid & out_ready.
out_last  out  1  marks the final payload byte; qualified by out_valid.
pkt_len  out  8  length of the frame being sent; stable during SEND.
busy  out  1  high in every state except IDLE.
err_len  out  1  one-cycle pulse: LEN is 0 or greater than MAX_LEN.
err_chk  out  1  one-cycle pulse: checksum mismatch.
err_timeout  out  1  one-cycle pulse: inter-byte timeout.
err_ovf  out  1  one-cycle pulse: byte arrived during SEND and was dropped.

Behaviour:
- Reset: state=IDLE. All outputs 0, including pkt_len, out_data, busy and all error pulses. Index, sum and timeout counters cleared. Buffer contents are don't-care. A reset in any state, including mid-SEND, aborts immediately with no further out_valid.
- States: IDLE, LEN, PAYLOAD, CHK, SEND. Byte handling below applies only in cycles where rx_valid=1.
- IDLE: a byte equal to SOF moves to LEN. Any other byte is ignored silently, with no error.
- LEN: a byte of 0 or greater than MAX_LEN pulses err_len and returns to IDLE. Otherwise latch len=byte, sum=byte, idx=0, and go to PAYLOAD.
- PAYLOAD: write buf[idx]=byte, sum=sum+byte (8-bit, wrap mod 256), idx=idx+1. On the byte where idx==len-1, go to CHK.
- CHK: if byte==sum, set pkt_len=len, idx=0, and go to SEND. Otherwise pulse err_chk and go to IDLE.
- Error pulses assert in the cycle after the offending rx_valid.
- SEND:
  - out_valid=1, out_data=buf[idx], out_last=(idx==len-1).
  - On a transfer, idx increments. A transfer with out_last set returns to IDLE, and out_valid drops the next cycle.
  - While out_ready=0, out_data and out_last hold stable.
  - Any rx_valid in SEND drops that byte and pulses err_ovf, including a SOF byte. There is no effect on the stream.
- Timeout (LEN, PAYLOAD, CHK only):
  - The counter clears on entry to these states and on every rx_valid; otherwise it increments.
  - When it reaches TIMEOUT_CLKS-1 with no byte in that cycle, pulse err_timeout and go to IDLE.
  - If rx_valid coincides with the terminal count, the byte is processed and there is no timeout.
- Latency: first out_valid is 1 cycle after the CHK byte strobe. Back-to-back transfers run at 1 byte/clk with out_ready held high.
- Buffer: MAX_LEN x 8 registers or inferred RAM. The read is combinational from idx, or registered with a one-cycle-ahead prefetch; either way out_data must be correct whenever out_valid=1.
- No two error pulses can assert in the same cycle.

Test Plan:
- Good frame: bytes AA 03 11 22 33 69 with out_ready=1 -> out stream 11,22,33 on consecutive cycles, out_last on 33, pkt_len=3, no error pulses, busy low afterwards.
- Bad checksum: AA 02 01 02 04 -> err_chk single pulse, out_valid never asserts, next frame AA 01 5A 5B -> single byte 5A with out_last.
- Length bounds: AA 00 -> err_len. AA 11 (17 > MAX_LEN) -> err_len. AA 10, 16 payload bytes 00..0F, chk 88 -> all 16 bytes out in order (sum 0x10+0x78=0x88).
- Timeout: AA 02 01, then idle for 8700 clks -> err_timeout exactly TIMEOUT_CLKS-1 clocks after the last byte, state IDLE. A byte landing on the terminal cycle does not time out.
- Backpressure/overrun: good frame AA 02 C3 3C FF, out_ready low 5 cycles -> out_data holds C3. An rx_valid byte 77 during SEND -> err_ovf, stream still C3,3C with out_last.
- Noise and reset: bytes 00 FF 55 before AA 01 42 43 -> noise ignored, 42 delivered. rst asserted mid-PAYLOAD -> all outputs 0, IDLE next cycle, following frame parses correctly.

Source files
------------

// File: rtl/uart_rx_pkt_parser.sv
// uart_rx_pkt_parser
//   Consumes bytes from a UART receiver and recognises frames of the form
//   SOF, LEN, payload[LEN], CHK.
//   CHK is the 8-bit wrapping sum of LEN and every payload byte.
//   The payload is buffered. It is released to the core as a valid/ready
//   byte stream only when the checksum matches.
//   Malformed, stalled or overrun traffic is dropped and flagged with a
//   one-cycle error pulse.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   rx_byte       received byte, qualified by rx_valid (one-cycle strobe)
//   out_data      payload byte, qualified by out_valid
//   out_valid     payload byte available
//   out_ready     downstream accepts (transfer on out_valid & out_ready)
//   out_last      final payload byte of the frame
//   pkt_len       length of the frame being sent (held after the frame)
//   busy          parser is not idle
//   err_len       LEN byte was 0 or larger than MAX_LEN
//   err_chk       checksum mismatch
//   err_timeout   inter-byte gap inside a frame exceeded TIMEOUT_CLKS
//   err_ovf       byte arrived while a frame was being sent and was dropped
module uart_rx_pkt_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF          = 8'hAA,
  parameter int         TIMEOUT_CLKS = 8700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] pkt_len,
  output logic       busy,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_ovf
);

  localparam int             IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TO_W      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_TERM  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_SEND
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      pkt_len_q, pkt_len_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_len_q, err_len_d;
  logic            err_chk_q, err_chk_d;
  logic            err_ovf_q, err_ovf_d;
  logic            buf_we;
  logic            timed;
  logic            to_expire;
  logic            is_last;
  logic [IDX_W-1:0] idx_a;
  logic [7:0]      buf_mem [MAX_LEN];

  // Checksum accumulation wraps modulo 256.
  function automatic logic [7:0] sum_wrap(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign idx_a   = idx_q[IDX_W-1:0];
  assign timed   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign is_last = (idx_q == len_q - 8'd1);

  // A byte arriving on the terminal count is processed instead of timing out,
  // so expiry has to see rx_valid in the same cycle.
  assign to_expire = timed && !rx_valid && (to_cnt_q == TO_TERM);

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    pkt_len_d = pkt_len_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovf_d = 1'b0;
    buf_we    = 1'b0;
    to_cnt_d  = (timed && !rx_valid) ? to_cnt_q + TO_W'(1) : '0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_byte == SOF)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (rx_valid) begin
          if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_byte;
            sum_d   = rx_byte;
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end else if (to_expire) begin
          state_d = S_IDLE;
        end
      end

      S_PAYLOAD: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          sum_d  = sum_wrap(sum_q, rx_byte);
          idx_d  = idx_q + 8'd1;
          if (is_last) begin
            state_d = S_CHK;
          end
        end else if (to_expire) begin
          state_d = S_IDLE;
        end
      end

      S_CHK: begin
        if (rx_valid) begin
          if (rx_byte == sum_q) begin
            pkt_len_d = len_q;
            idx_d     = 8'd0;
            state_d   = S_SEND;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (to_expire) begin
          state_d = S_IDLE;
        end
      end

      S_SEND: begin
        // Incoming bytes cannot be buffered while the payload is draining.
        if (rx_valid) begin
          err_ovf_d = 1'b1;
        end
        if (out_ready) begin
          if (is_last) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= 8'd0;
      sum_q     <= 8'd0;
      idx_q     <= 8'd0;
      pkt_len_q <= 8'd0;
      to_cnt_q  <= '0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      pkt_len_q <= pkt_len_d;
      to_cnt_q  <= to_cnt_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // Payload buffer: contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[idx_a] <= rx_byte;
    end
  end

  // Outputs
  // out_data is forced to zero outside SEND so stale buffer contents never
  // show on the bus, including straight after reset.
  assign out_valid   = (state_q == S_SEND);
  assign out_data    = out_valid ? buf_mem[idx_a] : 8'd0;
  assign out_last    = out_valid && is_last;
  assign pkt_len     = pkt_len_q;
  assign busy        = (state_q != S_IDLE);
  assign err_len     = err_len_q;
  assign err_chk     = err_chk_q;
  assign err_ovf     = err_ovf_q;
  assign err_timeout = to_expire;

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
module tb_uart_rx_pkt_parser;

  localparam int T = 8700;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic [7:0] pkt_len;
  logic       busy;
  logic       err_len, err_chk, err_timeout, err_ovf;

  uart_rx_pkt_parser #(.MAX_LEN(16), .SOF(8'hAA), .TIMEOUT_CLKS(T)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .pkt_len(pkt_len), .busy(busy),
    .err_len(err_len), .err_chk(err_chk), .err_timeout(err_timeout), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int n_len = 0, n_chk = 0, n_to = 0, n_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic [7:0] n);
    exp_t e;
    e.d = d; e.l = l; e.n = n;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || q.size() != 0) && k < 300) begin
      step();
      k++;
    end
    chk({name, "_drain"}, {31'd0, (busy || q.size() != 0)}, 32'd0);
    chk({name, "_valid_low"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_flags"}, {25'd0, out_valid, out_last, busy, err_len, err_chk, err_timeout, err_ovf}, 32'd0);
    chk({name, "_out_data"}, {24'd0, out_data}, 32'd0);
    chk({name, "_pkt_len"}, {24'd0, pkt_len}, 32'd0);
  endtask

  // Monitor: scoreboard for the output stream and error-pulse accounting
  always @(negedge clk) begin
    int ne;
    ne = int'(err_len) + int'(err_chk) + int'(err_timeout) + int'(err_ovf);
    if (ne != 0) chk("err_exclusive", ne, 1);
    if (err_len)     n_len++;
    if (err_chk)     n_chk++;
    if (err_timeout) n_to++;
    if (err_ovf)     n_ovf++;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e.d});
        chk("out_last", {31'd0, out_last}, {31'd0, e.l});
        chk("pkt_len",  {24'd0, pkt_len},  {24'd0, e.n});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;

    // Reset state
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Good frame: 03+11+22+33 = 69
    push(8'h11, 1'b0, 8'd3);
    push(8'h22, 1'b0, 8'd3);
    push(8'h33, 1'b1, 8'd3);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    chk("good_latency", {31'd0, out_valid}, 32'd1);
    step();
    chk("good_beat2", {31'd0, out_valid}, 32'd1);
    step();
    chk("good_beat3", {30'd0, out_valid, out_last}, 32'd3);
    step();
    chk("good_done", {30'd0, out_valid, busy}, 32'd0);

    // Bad checksum: 02+01+02 = 05, sent 04
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h04);
    chk("badchk_pulse", {30'd0, err_chk, out_valid}, 32'd2);
    step();
    chk("badchk_pulse_end", {30'd0, err_chk, busy}, 32'd0);
    push(8'h5A, 1'b1, 8'd1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
    wait_idle("after_badchk");

    // Length bounds
    send_byte(8'hAA); send_byte(8'h00);
    chk("len_zero", {30'd0, err_len, busy}, 32'd2);
    send_byte(8'hAA); send_byte(8'h11);
    chk("len_17", {30'd0, err_len, busy}, 32'd2);
    send_byte(8'hAA); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      push(8'(i), (i == 15), 8'd16);
      send_byte(8'(i));
    end
    send_byte(8'h88);
    wait_idle("len_max");

    // Timeout after last byte
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
    k = 0;
    while (!err_timeout && k < T + 10) begin
      step();
      k++;
    end
    chk("timeout_delay", k, T - 1);
    step();
    chk("timeout_idle", {30'd0, busy, err_timeout}, 32'd0);

    // Byte on the terminal count cycle is processed: 02+01+02 = 05
    push(8'h01, 1'b0, 8'd2);
    push(8'h02, 1'b1, 8'd2);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
    repeat (T - 1) step();
    send_byte(8'h02);
    chk("terminal_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h05);
    wait_idle("terminal");

    // Backpressure and overrun: 02+C3+3C = 0x101 -> 01
    out_ready = 1'b0;
    push(8'hC3, 1'b0, 8'd2);
    push(8'h3C, 1'b1, 8'd2);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'hC3);
    send_byte(8'h3C); send_byte(8'h01);
    chk("bp_hold0", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'hC3});
    send_byte(8'h77);
    chk("ovf_pulse", {31'd0, err_ovf}, 32'd1);
    chk("bp_hold1", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'hC3});
    send_byte(8'hAA);
    chk("ovf_sof_pulse", {31'd0, err_ovf}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'hC3});
    end
    out_ready = 1'b1;
    wait_idle("backpressure");

    // Noise before a frame
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h55);
    chk("noise_idle", {31'd0, busy}, 32'd0);
    push(8'h42, 1'b1, 8'd1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
    wait_idle("noise");

    // Reset mid-payload
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    step();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    push(8'h7E, 1'b1, 8'd1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    wait_idle("post_reset");

    step();
    chk("n_err_len", n_len, 2);
    chk("n_err_chk", n_chk, 1);
    chk("n_err_timeout", n_to, 1);
    chk("n_err_ovf", n_ovf, 2);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
